pc_gen: RTL

Parametrised fetch-stage program-counter generator with a built-in return-address stack (RAS). Each cycle it selects the next fetch address by fixed priority: trap vector, execute-stage redirect, RAS-predicted return, stall hold, sequential. It sits at the front of the five-stage pipeline, feeds the instruction memory address, and is the successor to the plain stall/next-PC register.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_gen_ras_stack.sv | 75 +++++++
 rtl/pc_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module  : pc_pkg
// Brief   : Shared defaults, PC type and next-PC select encoding for pc_gen.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int          XLEN_DEFAULT      = 32;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef logic [XLEN_DEFAULT-1:0] pc_t;

    typedef enum logic [2:0] {
        SEL_RESET    = 3'd0,
        SEL_TRAP     = 3'd1,
        SEL_REDIRECT = 3'd2,
        SEL_RAS      = 3'd3,
        SEL_HOLD     = 3'd4,
        SEL_SEQ      = 3'd5
    } pc_sel_e;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_gen_ras_stack.sv
// ============================================================================
// Module  : ras_stack
// Brief   : Circular return-address stack with overwrite-on-full and
//           pop+push top replacement.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, wr_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign top_data = mem_q[ptr_q];

    // ptr_q always addresses the current top; a push on a full stack simply
    // wraps onto the oldest entry while the count stays saturated.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !empty) begin
            wr_en = 1'b1;
        end else if (push) begin
            ptr_d  = ptr_q + PW'(1);
            wr_idx = ptr_d;
            wr_en  = 1'b1;
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule : ras_stack

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module  : pc_gen
// Brief   : Fetch-stage PC generator: trap > redirect > RAS return > hold >
//           sequential, with a built-in return-address stack.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            call_d,
    input  logic            ret_d,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_f,
    output logic            ras_underflow
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] ras_top, target;
    logic            misalign_q, misalign_d;
    logic            underflow_q, underflow_d;
    logic            flush, eff_call, eff_ret, ras_empty;
    pc_sel_e         sel;

    // A stalled or flushed decode slot must never disturb the RAS.
    assign flush    = trap_valid | redirect_e;
    assign eff_call = call_d & ~stall_f & ~flush;
    assign eff_ret  = ret_d  & ~stall_f & ~flush;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (eff_call),
        .pop       (eff_ret),
        .push_data (pc_d + XLEN'(4)),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

    assign pc_plus4 = fetch_pc_q + XLEN'(4);

    always_comb begin
        sel = SEL_SEQ;
        if (rst)                          sel = SEL_RESET;
        else if (trap_valid)              sel = SEL_TRAP;
        else if (redirect_e)              sel = SEL_REDIRECT;
        else if (eff_ret && !ras_empty)   sel = SEL_RAS;
        else if (stall_f)                 sel = SEL_HOLD;
    end

    always_comb begin
        target      = '0;
        fetch_pc_d  = pc_plus4;
        misalign_d  = 1'b0;
        underflow_d = eff_ret & ras_empty & ~eff_call;
        case (sel)
            SEL_TRAP:     target = trap_vec;
            SEL_REDIRECT: target = target_e;
            SEL_RAS:      target = ras_top;
            default:      target = '0;
        endcase
        case (sel)
            SEL_RESET: fetch_pc_d = RESET_VEC;
            SEL_TRAP, SEL_REDIRECT, SEL_RAS: begin
                fetch_pc_d = {target[XLEN-1:2], 2'b00};
                misalign_d = |target[1:0];
            end
            SEL_HOLD:  fetch_pc_d = fetch_pc_q;
            default:   fetch_pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_VEC;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc            = fetch_pc_q;
    assign misalign_f    = misalign_q;
    assign ras_underflow = underflow_q;

endmodule : pc_gen

`default_nettype wire
